// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier, parametrised on
// exponent and mantissa width. Round-to-nearest-even and flush-to-zero. Denormal
// inputs are treated as zero. Any NaN input gives a canonical quiet NaN.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   A, B                  operands {sign, exp, man}
//   out_valid / out_ready result handshake
//   result                product
//   overflow              finite operands rounded to infinity
//   underflow             nonzero finite product flushed to zero
//   invalid               infinity times zero
//
// Stages: S1 decode/classify/exponent sum, S2 mantissa product,
//         S3 normalise/round/pack/flags. The S3 registers drive the outputs.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int XLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            invalid
);

    localparam int PW = 2 * MAN_W + 2;  // full mantissa product width
    localparam int EW = EXP_W + 2;      // signed working exponent width
    localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);

    typedef enum logic [1:0] {K_FIN, K_ZERO, K_INF, K_NAN} kind_t;

    // The whole pipe either shifts or holds; nothing collapses bubbles.
    logic       adv;
    logic [3:1] vld_pipe;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];

    // ---------------- S1 decode ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    kind_t            kind_d;
    logic             inv_d;

    assign sa = A[XLEN-1];
    assign sb = B[XLEN-1];
    assign ea = A[XLEN-2 -: EXP_W];
    assign eb = B[XLEN-2 -: EXP_W];
    assign ma = A[MAN_W-1:0];
    assign mb = B[MAN_W-1:0];

    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = (&ea) & ~|ma;
    assign b_inf  = (&eb) & ~|mb;
    assign a_nan  = (&ea) & |ma;
    assign b_nan  = (&eb) & |mb;

    always_comb begin
        kind_d = K_FIN;
        inv_d  = 1'b0;
        if (a_nan | b_nan) begin
            kind_d = K_NAN;
        end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
            kind_d = K_NAN;
            inv_d  = 1'b1;
        end else if (a_inf | b_inf) begin
            kind_d = K_INF;
        end else if (a_zero | b_zero) begin
            kind_d = K_ZERO;
        end
    end

    logic                 s1_sign, s1_inv;
    kind_t                s1_kind;
    logic signed [EW-1:0] s1_exp;
    logic [MAN_W:0]       s1_ma, s1_mb;

    // ---------------- S2 product ----------------
    logic                 s2_sign, s2_inv;
    kind_t                s2_kind;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    // ---------------- S3 normalise / round ----------------
    logic                 p_msb, g_bit, r_bit, st_bit, rnd, carry;
    logic [PW-1:0]        norm;
    logic [MAN_W:0]       kept;
    logic [MAN_W+1:0]     mant_r;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] e_n, e_f;

    // Pre-shift so the leading one always sits at the top bit; the fields
    // below are then at fixed positions.
    assign p_msb  = s2_prod[PW-1];
    assign norm   = p_msb ? s2_prod : (s2_prod << 1);
    assign kept   = norm[PW-1 -: MAN_W+1];
    assign g_bit  = norm[MAN_W];
    assign r_bit  = norm[MAN_W-1];
    assign st_bit = |norm[MAN_W-2:0];
    assign rnd    = g_bit & (r_bit | st_bit | kept[0]);
    assign mant_r = {1'b0, kept} + {{(MAN_W+1){1'b0}}, rnd};
    // Carry out of rounding means the mantissa became exactly 2.0.
    assign carry  = mant_r[MAN_W+1];
    assign frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign e_n    = s2_exp + {{(EW-1){1'b0}}, p_msb};
    assign e_f    = e_n + {{(EW-1){1'b0}}, carry};

    logic [XLEN-1:0] res_d;
    logic            ov_d, un_d;

    always_comb begin
        res_d = '0;
        ov_d  = 1'b0;
        un_d  = 1'b0;
        case (s2_kind)
            K_NAN:  res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            K_INF:  res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            K_ZERO: res_d = {s2_sign, {(XLEN-1){1'b0}}};
            default: begin
                if (e_f >= EMAX) begin
                    res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ov_d  = 1'b1;
                end else if (e_f[EW-1] || (e_f == '0)) begin
                    res_d = {s2_sign, {(XLEN-1){1'b0}}};
                    un_d  = 1'b1;
                end else begin
                    res_d = {s2_sign, e_f[EXP_W-1:0], frac};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_sign   <= 1'b0;
            s1_inv    <= 1'b0;
            s1_kind   <= K_ZERO;
            s1_exp    <= '0;
            s1_ma     <= '0;
            s1_mb     <= '0;
            s2_sign   <= 1'b0;
            s2_inv    <= 1'b0;
            s2_kind   <= K_ZERO;
            s2_exp    <= '0;
            s2_prod   <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[2:1], in_valid};

            s1_sign <= sa ^ sb;
            s1_inv  <= inv_d;
            s1_kind <= kind_d;
            s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            s1_ma   <= {1'b1, ma};
            s1_mb   <= {1'b1, mb};

            s2_sign <= s1_sign;
            s2_inv  <= s1_inv;
            s2_kind <= s1_kind;
            s2_exp  <= s1_exp;
            s2_prod <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};

            // Flags (and result) read zero whenever no result is presented.
            if (vld_pipe[2]) begin
                result    <= res_d;
                overflow  <= ov_d;
                underflow <= un_d;
                invalid   <= s2_inv;
            end else begin
                result    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                invalid   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the single-precision combinational-style multiplier. Adds configurable exponent/mantissa widths, a 3-stage pipeline with valid/ready handshake, round-to-nearest-even, special-value handling and per-result exception flags.
- Sits between operand-issue logic and the FP result writeback of the datapath.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored mantissa field width (hidden bit excluded).
- XLEN, 1+EXP_W+MAN_W: operand/result width (derived; not overridden independently).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands A/B valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- A  in  XLEN  operand A {sign, exp, man}.
- B  in  XLEN  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  product.
- overflow  out  1  result rounded to infinity from finite operands.
- underflow  out  1  nonzero true result flushed to zero.
- invalid  out  1  inf × zero.

Behaviour:
- Reset (async, rst=1): all stage valid bits=0; out_valid=0, result=0, overflow=0, underflow=0, invalid=0. Asserting rst mid-operation discards all in-flight operations; no output follows from them.
- Pipeline: S1 decode/unpack/special classify/sign XOR/exponent sum; S2 (MAN_W+1)×(MAN_W+1) mantissa product; S3 normalise, RNE round, pack, flags. Output registers are S3.
- Advance rule: adv = ~out_valid | out_ready. When adv=1 all stages shift one position; when adv=0 all stages hold.
- in_ready = adv, combinational. A transfer occurs when in_valid & in_ready.
- Bubbles are not collapsed.
- Latency: exactly 3 cycles from input transfer to out_valid with out_ready held high. Throughput: 1/cycle.
- Holding: result and flags stay stable while out_valid=1 & out_ready=0.
- Sign: sA ^ sB for all results, including zero and inf. NaN is the exception.
- Input classification: exp==0 means zero; the mantissa is ignored (denormals are treated as zero). exp all-ones & man==0 means inf. exp all-ones & man!=0 means NaN.
- Special results, by priority:
  1. Any NaN input: canonical qNaN {0, all-ones exp, 1 followed by zeros}, no flags.
  2. inf × zero: canonical qNaN, invalid=1.
  3. inf × finite nonzero, or inf × inf: signed inf, no flags.
  4. Zero × finite: signed zero, no flags.
- Finite path:
  - Biased exponent e = eA + eB − (2^(EXP_W−1) − 1), computed signed in EXP_W+2 bits.
  - Product P is 2·MAN_W+2 bits. If its MSB is set, shift right 1 and e+1.
  - Keep MAN_W+1 bits, plus guard bit G, round bit R, and sticky S = OR of the remaining bits.
  - Round up if G & (R | S | lsb).
  - A mantissa carry-out on rounding renormalises, e+1.
- Range:
  - If final e ≥ 2^EXP_W − 1: signed inf, overflow=1.
  - If final e ≤ 0: signed zero, underflow=1 (flush-to-zero, no denormal output).
- Flags are registered alongside result and valid only with out_valid. They are 0 when out_valid=0.

Test Plan:
- Basic: A=0x3FC00000 (1.5), B=0x40000000 (2.0), in_valid pulse, out_ready=1 → 3 cycles later out_valid=1, result=0x40400000 (3.0), all flags 0.
- Sign/rounding:
  - 0xBF000000 × 0x40C00000 → 0xC0400000 (−3.0).
  - 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE, sticky set).
- Overflow/underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, no flags.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
- Backpressure:
  - Stream 4 back-to-back products with out_ready=0 from cycle 3 for 5 cycles → in_ready=0 once full, result held stable.
  - On out_ready=1, results emerge in order, none lost or duplicated.
- Reset mid-flight: issue 2 operations, assert rst 1 cycle after the second → outputs immediately 0, out_valid stays 0 after release until new input; a new op after release completes in 3 cycles.
